lfsr_prbs_gen: RTL and testbench

// Parametrised PRBS word generator: a Fibonacci or Galois LFSR advanced STEPS single-bit shifts per accepted word.

---
 rtl/lfsr_prbs_gen.sv | 174 +++++++++++++++++
 tb/tb_lfsr_prbs_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci/Galois PRBS word generator with a valid/ready output, seed load and lock-up recovery.
// Define LFSR_PERIOD_CNT_EN to add the o_period_wrap / o_period_words period-measurement outputs.
module lfsr_prbs_gen #(
  parameter int                TYPE         = 0,
  parameter int                EXTEND       = 0,
  parameter int                LENGTH       = 16,
  parameter logic [0:LENGTH-1] TAPS         = 16'h6801,
  parameter int                STEPS        = 1,
  parameter logic [0:LENGTH-1] DEFAULT_SEED = {LENGTH{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_load,
  input  logic [0:LENGTH-1] i_seed,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [0:STEPS-1]  o_out_data,
  output logic [0:LENGTH-1] o_state,
  output logic              o_lockup,
  output logic              o_running
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic              o_period_wrap,
  output logic [LENGTH:0]   o_period_words
`endif
);

  typedef enum logic {ST_IDLE, ST_RUN} fsm_t;

  fsm_t              r_fsm, w_fsm_next;
  logic [0:LENGTH-1] r_state;
  logic              r_out_valid;
  logic [0:STEPS-1]  r_out_data;
  logic              r_lockup;

  logic [0:LENGTH-1] w_next_state;
  logic [0:STEPS-1]  w_word;
  logic              w_seed_zero;
  logic              w_state_zero;
  logic [0:LENGTH-1] w_load_state;
  logic              w_advance;
  logic              w_consume;
  logic              w_recover;

  // With the de Bruijn extension the all-zero state is part of the sequence, so it is never illegal.
  assign w_seed_zero  = (EXTEND == 0) && (i_seed == '0);
  assign w_state_zero = (EXTEND == 0) && (r_state == '0);
  assign w_load_state = w_seed_zero ? DEFAULT_SEED : i_seed;

  // One output word is STEPS single-bit shifts unrolled into a single combinational cone.
  if (TYPE == 0) begin : g_fib
    always_comb begin
      logic [0:LENGTH-1] w_s;
      logic              w_fb;
      // NOTE: blocking assignments in always_comb; defaults first so no path leaves a latch.
      w_s    = r_state;
      w_fb   = 1'b0;
      w_word = '0;
      for (int k = 0; k < STEPS; k++) begin
        w_word[k] = w_s[LENGTH-1];
        w_fb      = ^(TAPS & w_s);
        if (EXTEND != 0) w_fb = w_fb ^ ~|w_s[0:LENGTH-2];
        w_s       = {w_fb, w_s[0:LENGTH-2]};
      end
      w_next_state = w_s;
    end
  end else begin : g_gal
    always_comb begin
      logic [0:LENGTH-1] w_s;
      logic [0:LENGTH-1] w_t;
      w_s    = r_state;
      w_t    = '0;
      w_word = '0;
      for (int k = 0; k < STEPS; k++) begin
        w_word[k] = w_s[LENGTH-1];
        w_t       = w_s ^ (TAPS & {LENGTH{w_s[LENGTH-1]}});
        w_s       = {w_t[LENGTH-1], w_t[0:LENGTH-2]};
      end
      w_next_state = w_s;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_advance  = 1'b0;
    w_consume  = 1'b0;
    w_recover  = 1'b0;
    case (r_fsm)
      ST_IDLE: if (i_load) w_fsm_next = ST_RUN;
      ST_RUN: begin
        if (!i_load) begin
          if (w_state_zero)                                w_recover = 1'b1;
          else if (i_enable && (!r_out_valid || i_out_ready)) w_advance = 1'b1;
          else if (r_out_valid && i_out_ready)             w_consume = 1'b1;
        end
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_fsm <= ST_IDLE;
    else       r_fsm <= w_fsm_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= DEFAULT_SEED;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_lockup    <= 1'b0;
    end else if (i_load) begin
      r_state     <= w_load_state;
      r_out_valid <= 1'b0;
      if (w_seed_zero) r_lockup <= 1'b1;
    end else if (w_recover) begin
      r_state     <= DEFAULT_SEED;
      r_out_valid <= 1'b0;
      r_lockup    <= 1'b1;
    end else if (w_advance) begin
      r_state     <= w_next_state;
      r_out_data  <= w_word;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_state     = r_state;
  assign o_lockup    = r_lockup;
  assign o_running   = (r_fsm == ST_RUN);

`ifdef LFSR_PERIOD_CNT_EN
  logic [0:LENGTH-1] r_seed_last;
  logic [LENGTH:0]   r_period_cnt;
  logic [LENGTH:0]   r_period_words;
  logic              r_period_wrap;
  logic [LENGTH:0]   w_cnt_inc;

  assign w_cnt_inc = r_period_cnt + (LENGTH+1)'(1);

  // Words are counted as they are generated; the wrap is detected on the post-step state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seed_last    <= DEFAULT_SEED;
      r_period_cnt   <= '0;
      r_period_words <= '0;
      r_period_wrap  <= 1'b0;
    end else begin
      r_period_wrap <= 1'b0;
      if (i_load) begin
        r_seed_last  <= w_load_state;
        r_period_cnt <= '0;
      end else if (w_advance) begin
        if (w_next_state == r_seed_last) begin
          r_period_wrap  <= 1'b1;
          r_period_words <= w_cnt_inc;
          r_period_cnt   <= '0;
        end else begin
          r_period_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign o_period_wrap  = r_period_wrap;
  assign o_period_words = r_period_words;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Self-checking bench: five generator configurations driven in lock-step, directed cases plus random traffic,
// every output compared each cycle against a shift-and-parity reference model.
module tb_lfsr_prbs_gen;

  localparam int ND = 5;

  typedef struct {
    int          typ;
    int          ext;
    int          len;
    logic [63:0] taps;
    int          steps;
    logic [63:0] dseed;
  } cfg_t;

  typedef struct {
    logic [63:0] st;
    logic        vld;
    logic [63:0] data;
    logic        lock;
    logic        run;
    int          cnt;
    logic        wrap;
    int          words;
    logic [63:0] seed_last;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, load, ready;
  logic [3:0]  seed4;
  logic [15:0] seed16;

  cfg_t cfg [ND];
  mdl_t m   [ND];

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] obs_state [ND];
  logic [63:0] obs_data  [ND];
  logic [63:0] obs_valid [ND];
  logic [63:0] obs_lock  [ND];
  logic [63:0] obs_run   [ND];
`ifdef LFSR_PERIOD_CNT_EN
  logic [63:0] obs_wrap  [ND];
  logic [63:0] obs_words [ND];
`endif

  logic [3:0]  st0, st1, st2, st3;
  logic [15:0] st4;
  logic [0:0]  dt0, dt3;
  logic [3:0]  dt1;
  logic [1:0]  dt2;
  logic [6:0]  dt4;
  logic        vl0, vl1, vl2, vl3, vl4;
  logic        lk0, lk1, lk2, lk3, lk4;
  logic        rn0, rn1, rn2, rn3, rn4;

`ifdef LFSR_PERIOD_CNT_EN
  logic        pw0, pw1, pw2, pw3, pw4;
  logic [4:0]  pn0, pn1, pn2, pn3;
  logic [16:0] pn4;
  `define PERIOD_PORTS(w, n) , .o_period_wrap(w), .o_period_words(n)
`else
  `define PERIOD_PORTS(w, n)
`endif

  lfsr_prbs_gen #(.TYPE(0), .EXTEND(0), .LENGTH(4), .TAPS(4'b0011), .STEPS(1), .DEFAULT_SEED(4'b1111)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_load(load), .i_seed(seed4), .o_out_valid(vl0),
    .i_out_ready(ready), .o_out_data(dt0), .o_state(st0), .o_lockup(lk0), .o_running(rn0) `PERIOD_PORTS(pw0, pn0));

  lfsr_prbs_gen #(.TYPE(0), .EXTEND(0), .LENGTH(4), .TAPS(4'b0011), .STEPS(4), .DEFAULT_SEED(4'b1111)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_load(load), .i_seed(seed4), .o_out_valid(vl1),
    .i_out_ready(ready), .o_out_data(dt1), .o_state(st1), .o_lockup(lk1), .o_running(rn1) `PERIOD_PORTS(pw1, pn1));

  lfsr_prbs_gen #(.TYPE(1), .EXTEND(0), .LENGTH(4), .TAPS(4'b0011), .STEPS(2), .DEFAULT_SEED(4'b1111)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_load(load), .i_seed(seed4), .o_out_valid(vl2),
    .i_out_ready(ready), .o_out_data(dt2), .o_state(st2), .o_lockup(lk2), .o_running(rn2) `PERIOD_PORTS(pw2, pn2));

  lfsr_prbs_gen #(.TYPE(0), .EXTEND(1), .LENGTH(4), .TAPS(4'b0011), .STEPS(1), .DEFAULT_SEED(4'b1111)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_load(load), .i_seed(seed4), .o_out_valid(vl3),
    .i_out_ready(ready), .o_out_data(dt3), .o_state(st3), .o_lockup(lk3), .o_running(rn3) `PERIOD_PORTS(pw3, pn3));

  lfsr_prbs_gen #(.TYPE(0), .EXTEND(0), .LENGTH(16), .TAPS(16'h6801), .STEPS(7), .DEFAULT_SEED(16'hFFFF)) u_d4 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_load(load), .i_seed(seed16), .o_out_valid(vl4),
    .i_out_ready(ready), .o_out_data(dt4), .o_state(st4), .o_lockup(lk4), .o_running(rn4) `PERIOD_PORTS(pw4, pn4));

  assign obs_state[0] = 64'(st0);  assign obs_data[0] = 64'(dt0);
  assign obs_state[1] = 64'(st1);  assign obs_data[1] = 64'(dt1);
  assign obs_state[2] = 64'(st2);  assign obs_data[2] = 64'(dt2);
  assign obs_state[3] = 64'(st3);  assign obs_data[3] = 64'(dt3);
  assign obs_state[4] = 64'(st4);  assign obs_data[4] = 64'(dt4);
  assign obs_valid[0] = 64'(vl0);  assign obs_lock[0] = 64'(lk0);  assign obs_run[0] = 64'(rn0);
  assign obs_valid[1] = 64'(vl1);  assign obs_lock[1] = 64'(lk1);  assign obs_run[1] = 64'(rn1);
  assign obs_valid[2] = 64'(vl2);  assign obs_lock[2] = 64'(lk2);  assign obs_run[2] = 64'(rn2);
  assign obs_valid[3] = 64'(vl3);  assign obs_lock[3] = 64'(lk3);  assign obs_run[3] = 64'(rn3);
  assign obs_valid[4] = 64'(vl4);  assign obs_lock[4] = 64'(lk4);  assign obs_run[4] = 64'(rn4);
`ifdef LFSR_PERIOD_CNT_EN
  assign obs_wrap[0] = 64'(pw0);  assign obs_words[0] = 64'(pn0);
  assign obs_wrap[1] = 64'(pw1);  assign obs_words[1] = 64'(pn1);
  assign obs_wrap[2] = 64'(pw2);  assign obs_words[2] = 64'(pn2);
  assign obs_wrap[3] = 64'(pw3);  assign obs_words[3] = 64'(pn3);
  assign obs_wrap[4] = 64'(pw4);  assign obs_words[4] = 64'(pn4);
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register held as a number whose bit 0 is the output stage: a shift is a right shift, feedback enters at the top.
  task automatic one_word(input cfg_t c, input logic [63:0] s_in, output logic [63:0] s_out, output logic [63:0] w);
    logic [63:0] s, t;
    logic        ob, fb;
    s = s_in;
    w = 64'd0;
    for (int k = 0; k < c.steps; k++) begin
      ob = s[0];
      w  = (w << 1) | 64'(ob);
      if (c.typ == 0) begin
        fb = ^(c.taps & s);
        if (c.ext != 0 && (s >> 1) == 64'd0) fb = ~fb;
        s = (s >> 1) | (64'(fb) << (c.len - 1));
      end else begin
        t = ob ? (s ^ c.taps) : s;
        s = (t >> 1) | (64'(t[0]) << (c.len - 1));
      end
    end
    s_out = s;
  endtask

  task automatic model_edge();
    logic [63:0] sd, ns, w;
    logic        zero_ok;
    for (int i = 0; i < ND; i++) begin
      sd      = (i == 4) ? 64'(seed16) : 64'(seed4);
      zero_ok = (cfg[i].ext != 0);
      if (rst) begin
        m[i].st = cfg[i].dseed; m[i].vld = 1'b0; m[i].data = 64'd0; m[i].lock = 1'b0; m[i].run = 1'b0;
        m[i].cnt = 0; m[i].wrap = 1'b0; m[i].words = 0; m[i].seed_last = cfg[i].dseed;
      end else begin
        m[i].wrap = 1'b0;
        if (load) begin
          if (sd == 64'd0 && !zero_ok) begin
            sd = cfg[i].dseed;
            m[i].lock = 1'b1;
          end
          m[i].st = sd; m[i].vld = 1'b0; m[i].run = 1'b1; m[i].cnt = 0; m[i].seed_last = sd;
        end else if (m[i].run) begin
          if (m[i].st == 64'd0 && !zero_ok) begin
            m[i].st = cfg[i].dseed; m[i].lock = 1'b1; m[i].vld = 1'b0;
          end else if (enable && (!m[i].vld || ready)) begin
            one_word(cfg[i], m[i].st, ns, w);
            m[i].st = ns; m[i].data = w; m[i].vld = 1'b1; m[i].cnt++;
            if (ns == m[i].seed_last) begin
              m[i].wrap = 1'b1; m[i].words = m[i].cnt; m[i].cnt = 0;
            end
          end else if (m[i].vld && ready) begin
            m[i].vld = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < ND; i++) begin
      check($sformatf("d%0d_state", i), obs_state[i], m[i].st);
      check($sformatf("d%0d_valid", i), obs_valid[i], 64'(m[i].vld));
      check($sformatf("d%0d_lockup", i), obs_lock[i], 64'(m[i].lock));
      check($sformatf("d%0d_running", i), obs_run[i], 64'(m[i].run));
      if (m[i].vld) check($sformatf("d%0d_data", i), obs_data[i], m[i].data);
`ifdef LFSR_PERIOD_CNT_EN
      check($sformatf("d%0d_wrap", i), obs_wrap[i], 64'(m[i].wrap));
      check($sformatf("d%0d_words", i), obs_words[i], 64'(m[i].words));
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [14:0] seq_bits;
    logic [15:0] seen;

    cfg[0] = '{0, 0, 4, 64'h3, 1, 64'hF};
    cfg[1] = '{0, 0, 4, 64'h3, 4, 64'hF};
    cfg[2] = '{1, 0, 4, 64'h3, 2, 64'hF};
    cfg[3] = '{0, 1, 4, 64'h3, 1, 64'hF};
    cfg[4] = '{0, 0, 16, 64'h6801, 7, 64'hFFFF};
    for (int i = 0; i < ND; i++) m[i] = '{64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 0, 1'b0, 0, 64'd0};

    rst = 1'b1; enable = 1'b0; load = 1'b0; ready = 1'b0; seed4 = 4'd0; seed16 = 16'd0;
    tick(); tick();
    check("rst_state", obs_state[0], 64'hF);
    check("rst_state16", obs_state[4], 64'hFFFF);
    check("rst_valid", obs_valid[0], 64'd0);
    check("rst_data", obs_data[0], 64'd0);
    check("rst_lockup", obs_lock[0], 64'd0);
    check("rst_running", obs_run[0], 64'd0);

    rst = 1'b0; enable = 1'b1; ready = 1'b1;
    repeat (3) tick();
    check("idle_running", obs_run[0], 64'd0);
    check("idle_valid", obs_valid[0], 64'd0);

    seed4 = 4'b1000; seed16 = 16'hACE1; load = 1'b1;
    tick();
    load = 1'b0;
    check("load_state", obs_state[0], 64'h8);
    check("load_running", obs_run[0], 64'd1);
    check("load_valid", obs_valid[0], 64'd0);
    tick();
    check("w1_data", obs_data[1], 64'b0001);
    check("w1_state", obs_state[1], 64'b1100);
    ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_data", obs_data[1], 64'b0001);
      check("bp_state", obs_state[1], 64'b1100);
      check("bp_valid", obs_valid[1], 64'd1);
    end
    ready = 1'b1;
    tick();
    check("w2_data", obs_data[1], 64'b0011);
    check("w2_state", obs_state[1], 64'b1010);
    tick();
    check("w3_data", obs_data[1], 64'b0101);
    check("w3_state", obs_state[1], 64'b0111);

    seq_bits = 15'b000100110101111;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("seq_bit", obs_data[0], 64'(seq_bits[14 - (i % 15)]));
`ifdef LFSR_PERIOD_CNT_EN
      if (i % 15 == 14) begin
        check("period_wrap", obs_wrap[0], 64'd1);
        check("period_words", obs_words[0], 64'd15);
      end
`endif
    end

    seed4 = 4'd0; seed16 = 16'd0; load = 1'b1;
    tick();
    load = 1'b0;
    check("zero_state_gal", obs_state[2], 64'hF);
    check("zero_lockup_gal", obs_lock[2], 64'd1);
    check("zero_valid_gal", obs_valid[2], 64'd0);
    check("zero_state_ext", obs_state[3], 64'd0);
    seen = 16'd1 << obs_state[3][3:0];
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | (16'd1 << obs_state[3][3:0]);
    end
    check("ext_all_states", 64'(seen), 64'hFFFF);
    check("ext_lockup", obs_lock[3], 64'd0);
    check("lockup_sticky", obs_lock[2], 64'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", obs_valid[3], 64'd0);
    check("midrst_running", obs_run[3], 64'd0);
    check("midrst_lockup", obs_lock[2], 64'd0);

    for (int c = 0; c < 800; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      load   = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 3) != 0);
      ready  = ($urandom_range(0, 2) != 0);
      seed4  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      seed16 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
